eqmat_decoder: RTL and testbench

- Inverse of the pairwise-equality matrix generator. It takes an N×N equality vector, where bit (i,j) = 1 iff x_i == x_j, and recovers the N-bit source vector x.
- The matrix cannot distinguish x from ~x, so an anchor input supplies the value of x_0.
- The block validates every row against the recovered vector and flags inconsistent matrices.
- Sits downstream of the matrix generator, or any equality-syndrome source, behind valid/ready handshakes.

---
 rtl/eqmat_pkg.sv | 21 ++
 rtl/eqmat_row_check.sv | 27 ++
 rtl/eqmat_decoder.sv | 171 +++++++++++++++++
 tb/tb_eqmat_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eqmat_pkg.sv
// Shared definitions for the equality-matrix decoder: FSM states, row-index width
// and the (i,j) -> flat bit index mapping of the N*N equality vector.
package eqmat_pkg;

    localparam int unsigned EQMAT_N = 5;
    localparam int unsigned ROW_W   = $clog2(EQMAT_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Entry (i,j) of an n x n matrix, row 0 in the MSBs.
    function automatic int unsigned idx(input int unsigned n,
                                        input int unsigned i,
                                        input int unsigned j);
        return n * n - 1 - (n * i + j);
    endfunction

endpackage

// File: rtl/eqmat_row_check.sv
// Combinational check of one matrix row against the decoded vector:
// flags a mismatch when row r differs from ~(x_r ^ x_j) for any j.
module eqmat_row_check
    import eqmat_pkg::*;
#(
    parameter int unsigned N  = EQMAT_N,
    parameter int unsigned RW = ROW_W
) (
    input  logic [N-1:0]  row_i,
    input  logic [N-1:0]  x_i,
    input  logic [RW-1:0] r_i,
    output logic          mismatch_c_o
);

    logic x_bits [N];
    logic x_r;

    for (genvar g = 0; g < N; g++) begin : g_xbit
        assign x_bits[g] = x_i[N-1-g];
    end

    assign x_r = x_bits[r_i];

    // Row r must equal x when x_r = 1 and ~x when x_r = 0.
    assign mismatch_c_o = (row_i != (x_r ? x_i : ~x_i));

endmodule

// File: rtl/eqmat_decoder.sv
// Recovers x from its pairwise-equality matrix, anchored by x_0, and validates one
// row per cycle. Optional macro EQMAT_EARLY_ABORT_EN ends the check at the first bad row.
module eqmat_decoder
    import eqmat_pkg::*;
#(
    parameter int unsigned N = EQMAT_N
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*N-1:0]       in_data,
    input  logic                 in_anchor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_err,
    output logic [$clog2(N)-1:0] out_err_row
);

    localparam int unsigned RW = $clog2(N);

    logic [1:0]     rst_sync_q;
    logic           rst_n;

    state_e         state_q, state_d;
    logic [N*N-1:0] m_q, m_d;
    logic           anchor_q, anchor_d;
    logic [RW-1:0]  row_q, row_d;
    logic           err_q, err_d;
    logic [RW-1:0]  err_row_q, err_row_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_err_q, out_err_d;
    logic [RW-1:0]  out_err_row_q, out_err_row_d;

    logic [N-1:0]   rows [N];
    logic [N-1:0]   row_sel;
    logic [N-1:0]   x_dec;
    logic           mismatch;
    logic           last_row;
    logic           finish;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Unpack the stored matrix into rows and decode x from row 0 and the anchor.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign rows[gi][N-1-gj] = m_q[idx(N, gi, gj)];
        end
        assign x_dec[N-1-gi] = anchor_q ^ ~m_q[idx(N, 0, gi)];
    end

    assign row_sel = rows[row_q];

    eqmat_row_check #(
        .N  (N),
        .RW (RW)
    ) u_row_check (
        .row_i        (row_sel),
        .x_i          (x_dec),
        .r_i          (row_q),
        .mismatch_c_o (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            m_q           <= '0;
            anchor_q      <= 1'b0;
            row_q         <= '0;
            err_q         <= 1'b0;
            err_row_q     <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            out_err_row_q <= '0;
        end else begin
            state_q       <= state_d;
            m_q           <= m_d;
            anchor_q      <= anchor_d;
            row_q         <= row_d;
            err_q         <= err_d;
            err_row_q     <= err_row_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            out_err_row_q <= out_err_row_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        m_d           = m_q;
        anchor_d      = anchor_q;
        row_d         = row_q;
        err_d         = err_q;
        err_row_d     = err_row_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        out_err_row_d = out_err_row_q;
        last_row      = (row_q == RW'(N - 1));
`ifdef EQMAT_EARLY_ABORT_EN
        finish        = last_row || mismatch;
`else
        finish        = last_row;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d        = in_data;
                    anchor_d   = in_anchor;
                    row_d      = '0;
                    err_d      = 1'b0;
                    err_row_d  = '0;
                    in_ready_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                // Only the first failing row is recorded.
                if (mismatch && !err_q) begin
                    err_d     = 1'b1;
                    err_row_d = row_q;
                end
                row_d = row_q + RW'(1);
                if (finish) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_data_d    = x_dec;
                    out_err_d     = err_d;
                    out_err_row_d = err_row_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign out_err_row = out_err_row_q;

endmodule

// File: tb/tb_eqmat_decoder.sv
// Self-checking bench for eqmat_decoder: directed vector table, handshake/reset
// sequences, and random matrices checked against an equality-based reference model.
module tb_eqmat_decoder;

    localparam int N  = 5;
    localparam int NN = N * N;
`ifdef EQMAT_EARLY_ABORT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          areset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NN-1:0] in_data = '0;
    logic          in_anchor = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_err;
    logic [2:0]    out_err_row;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eqmat_decoder #(.N(N)) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_anchor   (in_anchor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_err_row (out_err_row)
    );

    typedef struct {
        logic [NN-1:0] m;
        logic          a;
        logic [N-1:0]  x;
        logic          err;
        logic [2:0]    row;
        int            hold;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit mbit(input logic [NN-1:0] m, input int i, input int j);
        return bit'((m >> (NN - 1 - (N * i + j))) & NN'(1));
    endfunction

    function automatic bit xbit(input logic [N-1:0] x, input int i);
        return bit'((x >> (N - 1 - i)) & N'(1));
    endfunction

    // Matrix produced by the upstream generator for vector x.
    function automatic logic [NN-1:0] make_mat(input logic [N-1:0] x);
        logic [NN-1:0] m = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (xbit(x, i) == xbit(x, j))
                    m = m | (NN'(1) << (NN - 1 - (N * i + j)));
        return m;
    endfunction

    // x_j equals the anchor exactly where row 0 claims equality with x_0;
    // the first row disagreeing with those equalities is the error row.
    task automatic ref_model(input logic [NN-1:0] m, input logic a,
                             output logic [N-1:0] x, output logic err, output logic [2:0] row);
        bit xb [N];
        bit bad;
        x = '0; err = 1'b0; row = '0;
        for (int j = 0; j < N; j++) begin
            xb[j] = mbit(m, 0, j) ? a : !a;
            if (xb[j]) x = x | (N'(1) << (N - 1 - j));
        end
        for (int r = 0; r < N; r++) begin
            bad = 1'b0;
            for (int j = 0; j < N; j++)
                if (mbit(m, r, j) != (xb[r] == xb[j])) bad = 1'b1;
            if (bad && !err) begin
                err = 1'b1;
                row = 3'(r);
            end
        end
    endtask

    task automatic wait_valid(input string name, output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!out_valid) chk({name, ":timeout"}, 32'(out_valid), 32'd1);
    endtask

    // Entered and left at #1 after a rising edge with the block idle.
    task automatic run_one(input logic [NN-1:0] m, input logic a, input logic [N-1:0] ex,
                           input logic eerr, input logic [2:0] erow, input int hold,
                           input string name);
        int cnt;
        int lat;
        chk({name, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = m; in_anchor = a;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = NN'($urandom); in_anchor = 1'($urandom);
        wait_valid(name, cnt);
        lat = (EARLY && eerr) ? int'(erow) + 1 : N;
        chk({name, ":latency"}, 32'(cnt), 32'(lat));
        chk({name, ":data"}, 32'(out_data), 32'(ex));
        chk({name, ":err"}, 32'(out_err), 32'(eerr));
        chk({name, ":err_row"}, 32'(out_err_row), 32'(erow));
        chk({name, ":busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({name, ":hold"}, {21'd0, out_valid, in_ready, out_err, out_err_row, out_data},
                {21'd0, 1'b1, 1'b0, eerr, erow, ex});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, ":release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        areset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:outs", {22'd0, in_ready, out_valid, out_err, out_err_row, out_data}, {22'd0, 1'b1, 10'd0});
        areset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NN-1:0] m;
        logic [N-1:0]  x, ex;
        logic          a, eerr;
        logic [2:0]    erow;
        int            k, cnt;
        bit            seen;

        tbl[0] = '{25'h164DAC9, 1'b1, 5'b10110, 1'b0, 3'd0, 0};
        tbl[1] = '{25'h164DAC9, 1'b0, 5'b01001, 1'b0, 3'd0, 1};
        tbl[2] = '{25'h1FFFFFF, 1'b0, 5'b00000, 1'b0, 3'd0, 0};
        tbl[3] = '{25'h164D2C9, 1'b1, 5'b10110, 1'b1, 3'd2, 0};
        tbl[4] = '{25'h160DAC9, 1'b1, 5'b10110, 1'b1, 3'd1, 4};
        tbl[5] = '{25'h064DAC9, 1'b1, 5'b00110, 1'b1, 3'd0, 0};
        tbl[6] = '{25'h1FFFFFF, 1'b1, 5'b11111, 1'b0, 3'd0, 2};
        tbl[7] = '{25'h164DBC9, 1'b1, 5'b10110, 1'b1, 3'd3, 0};

        #2;
        do_reset();

        for (int i = 0; i < 8; i++)
            run_one(tbl[i].m, tbl[i].a, tbl[i].x, tbl[i].err, tbl[i].row, tbl[i].hold,
                    $sformatf("vec%0d", i));

        // Back-to-back matrices with out_ready held high: accept period is N+2.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 25'h1FFFFFF; in_anchor = 1'b0;
        @(posedge clk); #1;
        in_data = 25'h164DAC9; in_anchor = 1'b1;
        k = 0; seen = 1'b0;
        while (!in_ready && k < 30) begin
            if (out_valid) begin
                seen = 1'b1;
                chk("b2b:first", {26'd0, out_err, out_data}, 32'd0);
            end
            @(posedge clk); #1;
            k++;
        end
        chk("b2b:first_seen", 32'(seen), 32'd1);
        chk("b2b:period", 32'(k + 1), 32'(N + 2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b:accepted", 32'(in_ready), 32'd0);
        wait_valid("b2b", cnt);
        chk("b2b:second", {26'd0, out_err, out_data}, {26'd0, 1'b0, 5'b10110});
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b:idle", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset during CHECK cycle 2: in_ready returns at once, then a clean decode.
        in_valid = 1'b1; in_data = 25'h164D2C9; in_anchor = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        areset_n = 1'b0;
        #1;
        chk("rst_check:async", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        areset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_check:after", {22'd0, in_ready, out_valid, out_err, out_err_row, out_data}, {22'd0, 1'b1, 10'd0});
        run_one(25'h164DAC9, 1'b1, 5'b10110, 1'b0, 3'd0, 0, "rst_check:next");

        // Reset while a result is pending: out_valid drops asynchronously.
        in_valid = 1'b1; in_data = 25'h160DAC9; in_anchor = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("rst_done", cnt);
        #2;
        areset_n = 1'b0;
        #1;
        chk("rst_done:async", {21'd0, out_valid, in_ready, out_err, out_err_row, out_data}, {21'd0, 2'b01, 9'd0});
        @(posedge clk); #1;
        areset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_one(25'h164DAC9, 1'b0, 5'b01001, 1'b0, 3'd0, 0, "rst_done:next");

        // Random consistent matrices, some with flipped entries.
        for (int t = 0; t < 150; t++) begin
            x = N'($urandom);
            m = make_mat(x);
            a = 1'($urandom);
            if (t % 2 == 1) begin
                k = $urandom_range(1, 3);
                for (int f = 0; f < k; f++)
                    m = m ^ (NN'(1) << $urandom_range(0, NN - 1));
            end
            ref_model(m, a, ex, eerr, erow);
            run_one(m, a, ex, eerr, erow, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
